rename_ctrl: RTL and testbench

- Sequencing controller for the 4-wide register-rename stage, between decode and dispatch.
- Admits a decode group only when the physical-register free list and ROB can absorb the whole group, all-or-nothing.
- Drives the per-lane rename enables and the rd_valid qualifiers into the rename datapath, and holds a one-entry output register toward dispatch.
- On branch mispredict, blocks renaming for a fixed recovery window while the CRat and free list restore from architectural state.

---
 rtl/rename_ctrl.sv | 145 ++++++++++++++
 tb/tb_rename_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rename_ctrl.sv
// Rename-stage sequencing: all-or-nothing group admission against free list / ROB,
// per-lane rename drive, one-entry dispatch register and mispredict recovery window.

module rename_ctrl_lane (
  input  logic clock,
  input  logic reset,
  input  logic fire,
  input  logic flush,
  input  logic drain,
  input  logic in_valid,
  input  logic in_rd_valid,
  output logic rename_en,
  output logic rd_valid,
  output logic out_valid
);
  assign rename_en = fire & in_valid;
  assign rd_valid  = fire & in_valid & in_rd_valid;

  // flush beats a new load, a new load beats a drain
  always_ff @(posedge clock or posedge reset)
    if (reset)      out_valid <= 1'b0;
    else if (flush) out_valid <= 1'b0;
    else if (fire)  out_valid <= in_valid;
    else if (drain) out_valid <= 1'b0;
endmodule

module rename_ctrl #(
  parameter int FW             = 4,
  parameter int PREG_NUM       = 64,
  parameter int ROB_NUM        = 32,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_valid_0,
  input  logic        io_in_valid_1,
  input  logic        io_in_valid_2,
  input  logic        io_in_valid_3,
  input  logic        io_in_rd_valid_0,
  input  logic        io_in_rd_valid_1,
  input  logic        io_in_rd_valid_2,
  input  logic        io_in_rd_valid_3,
  input  logic [6:0]  io_free_count,
  input  logic        io_free_list_empty,
  input  logic [5:0]  io_rob_free,
  input  logic        io_dispatch_ready,
  input  logic        io_predict_fail,
  output logic        io_in_ready,
  output logic        io_rename_en_0,
  output logic        io_rename_en_1,
  output logic        io_rename_en_2,
  output logic        io_rename_en_3,
  output logic        io_rd_valid_0,
  output logic        io_rd_valid_1,
  output logic        io_rd_valid_2,
  output logic        io_rd_valid_3,
  output logic        io_out_valid_0,
  output logic        io_out_valid_1,
  output logic        io_out_valid_2,
  output logic        io_out_valid_3,
  output logic        io_recovering,
  output logic [31:0] io_stall_cycles
);
  localparam int CW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  typedef struct packed {
    logic valid;
    logic rd_valid;
  } lane_req_t;

  typedef enum logic {RUN, RECOVER} state_t;

  state_t           state;
  logic [CW-1:0]    rcnt;
  lane_req_t [FW-1:0] req;
  logic [FW-1:0]    in_valid, rename_en, rd_valid, out_valid;
  logic [2:0]       need_preg, need_rob;
  logic             out_free, fire;

  assign req[0] = '{valid: io_in_valid_0, rd_valid: io_in_rd_valid_0};
  assign req[1] = '{valid: io_in_valid_1, rd_valid: io_in_rd_valid_1};
  assign req[2] = '{valid: io_in_valid_2, rd_valid: io_in_rd_valid_2};
  assign req[3] = '{valid: io_in_valid_3, rd_valid: io_in_rd_valid_3};

  always_comb begin
    need_preg = '0;
    need_rob  = '0;
    for (int i = 0; i < FW; i++) begin
      in_valid[i] = req[i].valid;
      need_preg   = need_preg + {2'b00, req[i].valid & req[i].rd_valid};
      need_rob    = need_rob  + {2'b00, req[i].valid};
    end
  end

  assign out_free    = ~(|out_valid) | io_dispatch_ready;
  assign io_in_ready = (state == RUN) & ~io_predict_fail & ~io_free_list_empty &
                       ({4'b0, need_preg} <= io_free_count) &
                       ({3'b0, need_rob} <= io_rob_free) & out_free;
  assign fire        = io_in_ready & (|in_valid);

  for (genvar g = 0; g < FW; g++) begin : g_lane
    rename_ctrl_lane u_lane (
      .clock       (clock),
      .reset       (reset),
      .fire        (fire),
      .flush       (io_predict_fail),
      .drain       (io_dispatch_ready),
      .in_valid    (req[g].valid),
      .in_rd_valid (req[g].rd_valid),
      .rename_en   (rename_en[g]),
      .rd_valid    (rd_valid[g]),
      .out_valid   (out_valid[g])
    );
  end

  assign {io_rename_en_3, io_rename_en_2, io_rename_en_1, io_rename_en_0} = rename_en;
  assign {io_rd_valid_3, io_rd_valid_2, io_rd_valid_1, io_rd_valid_0}     = rd_valid;
  assign {io_out_valid_3, io_out_valid_2, io_out_valid_1, io_out_valid_0} = out_valid;
  assign io_recovering = (state == RECOVER);

  // a fail seen while already recovering restarts the window
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= RUN;
      rcnt  <= '0;
    end else begin
      case (state)
        RUN: if (io_predict_fail) begin
          state <= RECOVER;
          rcnt  <= CW'(RECOVER_CYCLES - 1);
        end
        RECOVER: begin
          if (io_predict_fail) rcnt  <= CW'(RECOVER_CYCLES - 1);
          else if (rcnt != '0) rcnt  <= rcnt - 1'b1;
          else                 state <= RUN;
        end
        default: state <= RUN;
      endcase
    end

  always_ff @(posedge clock or posedge reset)
    if (reset) io_stall_cycles <= '0;
    else if ((state == RUN) & ~io_predict_fail & (|in_valid) & ~io_in_ready)
      io_stall_cycles <= io_stall_cycles + 32'd1;
endmodule

// File: tb/tb_rename_ctrl.sv
// Random + directed stimulus against a cycle-level behavioural model of the rename controller;
// expectations are queued per cycle and checked by an independent monitor.
module tb_rename_ctrl;
  localparam int RC = 2;

  logic clock = 1'b0, reset = 1'b1;
  logic [3:0] v, rd;
  logic [6:0] fc;
  logic fle, dr, pf;
  logic [5:0] rf;
  logic in_ready, recovering;
  logic [3:0] ren, rdv, ov;
  logic [31:0] stall;

  always #5 clock = ~clock;

  rename_ctrl #(.RECOVER_CYCLES(RC)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid_0(v[0]), .io_in_valid_1(v[1]), .io_in_valid_2(v[2]), .io_in_valid_3(v[3]),
    .io_in_rd_valid_0(rd[0]), .io_in_rd_valid_1(rd[1]), .io_in_rd_valid_2(rd[2]), .io_in_rd_valid_3(rd[3]),
    .io_free_count(fc), .io_free_list_empty(fle), .io_rob_free(rf),
    .io_dispatch_ready(dr), .io_predict_fail(pf), .io_in_ready(in_ready),
    .io_rename_en_0(ren[0]), .io_rename_en_1(ren[1]), .io_rename_en_2(ren[2]), .io_rename_en_3(ren[3]),
    .io_rd_valid_0(rdv[0]), .io_rd_valid_1(rdv[1]), .io_rd_valid_2(rdv[2]), .io_rd_valid_3(rdv[3]),
    .io_out_valid_0(ov[0]), .io_out_valid_1(ov[1]), .io_out_valid_2(ov[2]), .io_out_valid_3(ov[3]),
    .io_recovering(recovering), .io_stall_cycles(stall)
  );

  typedef struct {
    logic        rdy;
    logic [3:0]  ren, rdv, ov;
    logic        rec;
    logic [31:0] stall;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0, n_fail = 0;

  // model state: cycles of blocking left, dispatch register, stall counter
  int          m_block = 0;
  logic [3:0]  m_ov = '0;
  logic [31:0] m_stall = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle, queue the expected outputs, advance the model.
  task automatic cyc(input logic [3:0] iv, input logic [3:0] ird, input int ifc, input logic ifle,
                     input int irf, input logic idr, input logic ipf);
    exp_t e;
    int np, nr;
    logic rdy, fire;
    @(posedge clock); #1;
    v = iv; rd = ird; fc = 7'(ifc); fle = ifle; rf = 6'(irf); dr = idr; pf = ipf;
    np = $countones(iv & ird);
    nr = $countones(iv);
    rdy  = (m_block == 0) && !ipf && !ifle && (np <= ifc) && (nr <= irf) && ((m_ov == 0) || idr);
    fire = rdy && (iv != 0);
    e.rdy = rdy; e.ren = fire ? iv : 4'b0; e.rdv = fire ? (iv & ird) : 4'b0;
    e.ov = m_ov; e.rec = (m_block > 0); e.stall = m_stall;
    exp_q.push_back(e);
    if (m_block == 0 && !ipf && iv != 0 && !rdy) m_stall = m_stall + 1;
    if (ipf) m_block = RC; else if (m_block > 0) m_block--;
    if (ipf) m_ov = 0; else if (fire) m_ov = iv; else if (idr) m_ov = 0;
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("in_ready", 32'(in_ready), 32'(e.rdy));
      chk("rename_en", 32'(ren), 32'(e.ren));
      chk("rd_valid", 32'(rdv), 32'(e.rdv));
      chk("out_valid", 32'(ov), 32'(e.ov));
      chk("recovering", 32'(recovering), 32'(e.rec));
      chk("stall_cycles", stall, e.stall);
    end
  end

  initial begin
    v = '0; rd = '0; fc = '0; fle = 1'b0; rf = '0; dr = 1'b0; pf = 1'b0;
    #1;
    chk("reset_out_valid", 32'(ov), 32'h0);
    chk("reset_recovering", 32'(recovering), 32'h0);
    chk("reset_stall", stall, 32'h0);
    @(posedge clock); #2 reset = 1'b0;

    // full group with exact free count, then a short free count stalls
    cyc(4'hF, 4'hF, 4, 0, 32, 1, 0);
    cyc(4'hF, 4'hF, 3, 0, 32, 1, 0);
    cyc(4'hF, 4'hF, 3, 0, 32, 1, 0);
    cyc(4'hF, 4'hF, 4, 0, 32, 1, 0);
    // ROB limit, then fire with partial rd
    cyc(4'hF, 4'h5, 2, 0, 3, 1, 0);
    cyc(4'hF, 4'h5, 2, 0, 4, 1, 0);
    // held output blocks new groups
    cyc(4'h3, 4'h1, 8, 0, 32, 0, 0);
    cyc(4'hC, 4'hC, 8, 0, 32, 0, 0);
    cyc(4'hC, 4'hC, 8, 0, 32, 0, 0);
    cyc(4'hC, 4'hC, 8, 0, 32, 0, 0);
    cyc(4'hC, 4'hC, 8, 0, 32, 1, 0);
    // no-destination group with free_count 0; free_list_empty override; rob_free 0
    cyc(4'h6, 4'h0, 0, 0, 32, 1, 0);
    cyc(4'h1, 4'h1, 40, 1, 32, 1, 0);
    cyc(4'h1, 4'h0, 40, 0, 0, 1, 0);
    // mispredict with acceptable group, recovery window, then a double pulse
    cyc(4'hF, 4'hF, 64, 0, 32, 1, 0);
    cyc(4'hF, 4'hF, 64, 0, 32, 0, 1);
    for (int i = 0; i < 3; i++) cyc(4'hF, 4'hF, 64, 0, 32, 1, 0);
    cyc(4'hF, 4'hF, 64, 0, 32, 1, 1);
    cyc(4'hF, 4'hF, 64, 0, 32, 1, 1);
    for (int i = 0; i < 4; i++) cyc(4'hF, 4'hF, 64, 0, 32, 1, 0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      int ifc, irf;
      ifc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 64)) : int'($urandom_range(0, 5));
      irf = ($urandom_range(0, 7) == 0) ? 32 : int'($urandom_range(0, 5));
      cyc(4'($urandom), 4'($urandom), ifc, ($urandom_range(0, 15) == 0),
          irf, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0));
    end

    // asynchronous reset in the middle of a recovery window
    cyc(4'hF, 4'hF, 64, 0, 32, 1, 0);
    cyc(4'h0, 4'h0, 64, 0, 32, 1, 1);
    @(posedge clock); #1;
    v = 4'h0; pf = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("arst_recovering", 32'(recovering), 32'h0);
    chk("arst_out_valid", 32'(ov), 32'h0);
    chk("arst_stall", stall, 32'h0);
    m_block = 0; m_ov = '0; m_stall = '0;
    @(posedge clock); #1 reset = 1'b0;
    exp_q.push_back('{rdy: 1'b1, ren: 4'h0, rdv: 4'h0, ov: 4'h0, rec: 1'b0, stall: 32'h0});
    cyc(4'hF, 4'hF, 4, 0, 4, 1, 0);
    cyc(4'h0, 4'h0, 4, 0, 4, 1, 0);
    @(posedge clock); @(posedge clock);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
